// File: rtl/btn_event_gen_if.sv
// -----------------------------------------------------------------------------
// btn_event_gen_if
// Bundles the debounced button level with the event outputs derived from it.
// "release" and "repeat" are reserved words in SystemVerilog, so those pulses
// carry a _pulse suffix here.
//
// Signals:
//   btn_state      debounced button level, 1 = pressed (into the generator)
//   press          one-cycle pulse on press
//   release_pulse  one-cycle pulse on release
//   long_press     one-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_pulse   one-cycle pulse every REPEAT_CYCLES after long_press
//   held           high while a press is in progress
//
// Modports:
//   master  the event generator (consumes btn_state, drives the events)
//   slave   the game/control logic consuming the events
// -----------------------------------------------------------------------------
interface btn_event_gen_if;
    logic btn_state;
    logic press;
    logic release_pulse;
    logic long_press;
    logic repeat_pulse;
    logic held;

    modport master (
        input  btn_state,
        output press,
        output release_pulse,
        output long_press,
        output repeat_pulse,
        output held
    );

    modport slave (
        output btn_state,
        input  press,
        input  release_pulse,
        input  long_press,
        input  repeat_pulse,
        input  held
    );
endinterface

// File: rtl/btn_event_gen.sv
// -----------------------------------------------------------------------------
// btn_event_gen
// Turns a debounced button level into single-cycle event pulses: press,
// release, long-press and auto-repeat. It also provides a registered "held"
// level. All outputs are registered. Each pulse is high for the one cycle
// after the clock edge at which its cause is sampled.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   evt    btn_event_gen_if.master: btn_state in; press, release_pulse,
//          long_press, repeat_pulse and held out
//
// Parameters:
//   LONG_CYCLES    hold time in clocks before long_press fires (>= 2)
//   REPEAT_CYCLES  repeat period after long_press; 0 disables repeat (else >= 2)
//   CNT_W          hold-counter width; 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES)
// -----------------------------------------------------------------------------
module btn_event_gen #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    btn_event_gen_if.master   evt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_LONG    = 2'd2;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_q, btn_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;
    logic             rise;

    always_comb begin
        btn_d     = evt.btn_state;
        rise      = evt.btn_state & ~btn_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        // A low level always wins over a terminal count, so release takes
        // priority and the other pulses stay mutually exclusive.
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end
            end
            ST_PRESSED: begin
                if (!evt.btn_state) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_LONG;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_LONG: begin
                if (!evt.btn_state) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if ((REPEAT_CYCLES != 0) && (cnt_q == REP_LAST)) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else if (cnt_q != CNT_MAX) begin
                    // With repeat disabled the counter parks at all-ones
                    // instead of wrapping through a long hold.
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Registered alongside the pulses: rises with press, falls with release.
        held_d = (state_d != ST_IDLE);
    end

    // btn_q resets high so a button held through reset does not look like a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            btn_q     <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            btn_q     <= btn_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign evt.press         = press_q;
    assign evt.release_pulse = release_q;
    assign evt.long_press    = long_q;
    assign evt.repeat_pulse  = repeat_q;
    assign evt.held          = held_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// -----------------------------------------------------------------------------
// tb_btn_event_gen
// Two instances share clk, rst_n and the button level: dut_a with
// LONG_CYCLES=8, REPEAT_CYCLES=4 and dut_b with LONG_CYCLES=8, REPEAT_CYCLES=0.
// A reference model tracks, per instance, whether a press is active and how
// many cycles it has been held. It derives each cycle's expected
// {press, release, long_press, repeat, held} from that.
// -----------------------------------------------------------------------------
module tb_btn_event_gen;

    localparam int LONG = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    btn_event_gen_if ifa ();
    btn_event_gen_if ifb ();

    assign ifa.btn_state = btn;
    assign ifb.btn_state = btn;

    btn_event_gen #(.LONG_CYCLES(LONG), .REPEAT_CYCLES(4), .CNT_W(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .evt   (ifa)
    );

    btn_event_gen #(.LONG_CYCLES(LONG), .REPEAT_CYCLES(0), .CNT_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .evt   (ifb)
    );

    always #5 clk = ~clk;

    logic [4:0] obs_a, obs_b;
    assign obs_a = {ifa.press, ifa.release_pulse, ifa.long_press, ifa.repeat_pulse, ifa.held};
    assign obs_b = {ifb.press, ifb.release_pulse, ifb.long_press, ifb.repeat_pulse, ifb.held};

    // Reference model state
    bit         m_bprev;
    bit         m_active [2];
    int         m_k      [2];
    logic [4:0] m_exp    [2];
    int         m_rep    [2];

    // Event tallies for dut_a, and for dut_b's long/repeat pulses
    int c_press, c_rel, c_long, c_rep, c_long_b, c_rep_b;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bprev = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_k[i]      = 0;
            m_exp[i]    = '0;
        end
    endtask

    // One clock edge at which button level b is sampled.
    task automatic model_edge(input bit b);
        bit rise;
        bit p, r, l, rp;
        rise = b & ~m_bprev;
        for (int i = 0; i < 2; i++) begin
            p = 0; r = 0; l = 0; rp = 0;
            if (!m_active[i]) begin
                if (rise) begin
                    p = 1;
                    m_active[i] = 1;
                    m_k[i] = 0;
                end
            end else if (!b) begin
                r = 1;
                m_active[i] = 0;
            end else begin
                m_k[i]++;
                if (m_k[i] == LONG)
                    l = 1;
                else if (m_k[i] > LONG && m_rep[i] != 0 && ((m_k[i] - LONG) % m_rep[i]) == 0)
                    rp = 1;
            end
            m_exp[i] = {p, r, l, rp, m_active[i]};
        end
        m_bprev = b;
    endtask

    task automatic clear_counts();
        c_press = 0; c_rel = 0; c_long = 0; c_rep = 0; c_long_b = 0; c_rep_b = 0;
    endtask

    task automatic step(input bit b);
        btn = b;
        @(posedge clk);
        model_edge(b);
        #1;
        check_eq("out_a", 32'(obs_a), 32'(m_exp[0]));
        check_eq("out_b", 32'(obs_b), 32'(m_exp[1]));
        c_press  += int'(ifa.press);
        c_rel    += int'(ifa.release_pulse);
        c_long   += int'(ifa.long_press);
        c_rep    += int'(ifa.repeat_pulse);
        c_long_b += int'(ifb.long_press);
        c_rep_b  += int'(ifb.repeat_pulse);
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic apply_reset(input bit b);
        btn = b;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_async_a", 32'(obs_a), 32'd0);
        check_eq("rst_async_b", 32'(obs_b), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hold_a", 32'(obs_a), 32'd0);
        check_eq("rst_hold_b", 32'(obs_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        bit lvl;
        m_rep[0] = 4;
        m_rep[1] = 0;
        model_reset();
        clear_counts();

        // 1: short press
        #1;
        apply_reset(1'b0);
        step(1'b0);
        clear_counts();
        repeat (3) step(1'b1);
        step(1'b0);
        step(1'b0);
        check_eq("t1_press", c_press, 1);
        check_eq("t1_release", c_rel, 1);
        check_eq("t1_long", c_long, 0);

        // 2: hold 20 cycles, fall on a repeat terminal cycle
        clear_counts();
        repeat (20) step(1'b1);
        step(1'b0);
        step(1'b0);
        check_eq("t2_press", c_press, 1);
        check_eq("t2_long", c_long, 1);
        check_eq("t2_repeat", c_rep, 2);
        check_eq("t2_release", c_rel, 1);

        // 3: fall on the long-press terminal cycle
        clear_counts();
        repeat (8) step(1'b1);
        step(1'b0);
        step(1'b0);
        check_eq("t3_long", c_long, 0);
        check_eq("t3_release", c_rel, 1);

        // 4: button held through reset
        apply_reset(1'b1);
        clear_counts();
        repeat (3) step(1'b1);
        check_eq("t4_no_press", c_press, 0);
        repeat (2) step(1'b0);
        step(1'b1);
        check_eq("t4_press", c_press, 1);

        // 5: reset while in the long state, then no release afterwards
        repeat (12) step(1'b1);
        apply_reset(1'b1);
        clear_counts();
        repeat (3) step(1'b1);
        repeat (2) step(1'b0);
        check_eq("t5_no_release", c_rel, 0);
        check_eq("t5_no_press", c_press, 0);

        // 6: long hold on the repeat-disabled instance
        clear_counts();
        repeat (30) step(1'b1);
        step(1'b0);
        step(1'b0);
        check_eq("t6_long_b", c_long_b, 1);
        check_eq("t6_repeat_b", c_rep_b, 0);

        // Random runs of button levels with occasional resets
        lvl = 1'b0;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                apply_reset(1'($urandom_range(0, 1)));
            end
            lvl = ~lvl;
            len = (lvl && $urandom_range(0, 2) == 0) ? $urandom_range(8, 40)
                                                     : $urandom_range(1, 12);
            for (int j = 0; j < len; j++) step(lvl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
